instr_fetch: RTL and testbench

Instruction fetch unit for the 9-bit custom CPU: it owns the program counter, drives the synchronous instruction ROM, and presents each fetched machine word to the control decoder with a valid qualifier. It is the producer side of the decoder interface: it feeds the opcode and type fields, consumes the decoder's `Branch` output plus the ALU condition, and redirects fetch to absolute branch targets. It also implements the `Start`/`Done` program handshake with the testbench or top level.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the synchronous ROM, squashes after taken branches.
// Optional FETCH_ICOUNT_EN adds a saturating 16-bit issued-instruction counter on IssueCount.
module instr_fetch #(
   parameter int unsigned PC_W = 10,
   parameter int unsigned IW   = 9
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   output logic [PC_W-1:0] RomAddr,
   input  logic [IW-1:0]   RomData,
   output logic [IW-1:0]   Instr,
   output logic            InstrValid,
   output logic [PC_W-1:0] PcOut,
   input  logic            Branch,
   input  logic            Taken,
   input  logic [PC_W-1:0] Target,
   output logic            Done
`ifdef FETCH_ICOUNT_EN
   ,
   output logic [15:0]     IssueCount
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] fp_q, fp_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            halt;
   logic            squash;

   assign halt   = valid_q & (&RomData);
   // A taken branch kills the sequential word already being read from the ROM.
   assign squash = valid_q & Branch & Taken;

   always_comb begin
      state_d = state_q;
      fp_d    = fp_q;
      pc_d    = pc_q;
      valid_d = 1'b0;
      done_d  = done_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StRun;
               fp_d    = '0;
            end
         end
         StRun: begin
            if (halt) begin
               state_d = StHalt;
               done_d  = 1'b1;
            end else begin
               pc_d    = fp_q;
               fp_d    = squash ? Target : fp_q + 1'b1;
               valid_d = !squash;
            end
         end
         StHalt: begin
            if (Start) begin
               state_d = StRun;
               fp_d    = '0;
               done_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         fp_q    <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fp_q    <= fp_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

`ifdef FETCH_ICOUNT_EN
   logic [15:0] icnt_q, icnt_d;

   always_comb begin
      icnt_d = icnt_q;
      if (state_q != StRun && Start) begin
         icnt_d = '0;
      end else if (valid_q && !halt && icnt_q != 16'hFFFF) begin
         icnt_d = icnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         icnt_q <= '0;
      end else begin
         icnt_q <= icnt_d;
      end
   end

   assign IssueCount = icnt_q;
`endif

   assign RomAddr    = fp_q;
   assign Instr      = RomData;
   assign InstrValid = valid_q;
   assign PcOut      = pc_q;
   assign Done       = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed trace table, program-level reference model with
// random programs, reset during a taken branch, and a 4-bit PC wrap instance.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [9:0] rom_addr, pc_out, target;
   logic [8:0] rom_data, instr;
   logic       instr_valid, branch, taken, done;

   logic       r4, s4;
   logic [3:0] rom_addr4, pc4;
   logic [8:0] instr4;
   logic       v4, done4;

`ifdef FETCH_ICOUNT_EN
   logic [15:0] icnt, icnt4;
`endif

   logic [8:0] rom[1024];
   logic       br[1024];
   logic       tk[1024];
   logic [9:0] tg[1024];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_fetch #(.PC_W(10), .IW(9)) dut (
      .Clk(clk), .Reset(reset), .Start(start), .RomAddr(rom_addr), .RomData(rom_data),
      .Instr(instr), .InstrValid(instr_valid), .PcOut(pc_out), .Branch(branch),
      .Taken(taken), .Target(target), .Done(done)
`ifdef FETCH_ICOUNT_EN
      , .IssueCount(icnt)
`endif
   );

   instr_fetch #(.PC_W(4), .IW(9)) dut4 (
      .Clk(clk), .Reset(r4), .Start(s4), .RomAddr(rom_addr4), .RomData(9'h000),
      .Instr(instr4), .InstrValid(v4), .PcOut(pc4), .Branch(1'b0),
      .Taken(1'b0), .Target(4'h0), .Done(done4)
`ifdef FETCH_ICOUNT_EN
      , .IssueCount(icnt4)
`endif
   );

   // Synchronous ROM and a table-driven decoder keyed on the issued address.
   always @(posedge clk) rom_data <= rom[rom_addr];
   assign branch = br[pc_out];
   assign taken  = tk[pc_out];
   assign target = tg[pc_out];

   typedef struct packed {
      logic       start;
      logic       v;
      logic [9:0] pc;
      logic       done;
   } row_t;

   typedef struct packed {
      logic       v;
      logic [9:0] pc;
      logic       done;
   } ev_t;

   row_t tbl[17];
   ev_t  exq[$];
   int   exp_issued;
   logic exp_halted;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {20'd0, done, instr_valid, instr_valid ? pc_out : 10'd0};
   endfunction

   function automatic logic [31:0] want(input logic v, input logic [9:0] pc, input logic d);
      return {20'd0, d, v, v ? pc : 10'd0};
   endfunction

   task automatic clear_prog();
      for (int a = 0; a < 1024; a++) begin
         rom[a] = 9'h000;
         br[a]  = 1'b0;
         tk[a]  = 1'b0;
         tg[a]  = 10'd0;
      end
   endtask

   // Program-level model: walks the program by the ISA rules and lists per-cycle outcomes.
   task automatic build_model(input int maxcyc);
      int         pc = 0;
      logic       bub = 1'b0;
      exq.delete();
      exp_issued = 0;
      exp_halted = 1'b0;
      while (exq.size() < maxcyc && !exp_halted) begin
         if (bub) begin
            exq.push_back('{v: 1'b0, pc: 10'd0, done: 1'b0});
            bub = 1'b0;
         end else if (rom[pc] == 9'h1FF) begin
            exq.push_back('{v: 1'b1, pc: 10'(pc), done: 1'b0});
            exq.push_back('{v: 1'b0, pc: 10'd0, done: 1'b1});
            exp_halted = 1'b1;
         end else begin
            exq.push_back('{v: 1'b1, pc: 10'(pc), done: 1'b0});
            exp_issued++;
            if (br[pc] && tk[pc]) begin
               pc  = int'(tg[pc]);
               bub = 1'b1;
            end else begin
               pc = (pc + 1) % 1024;
            end
         end
      end
   endtask

   task automatic run_prog(input string name, input int maxcyc);
      build_model(maxcyc);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk({name, "_reset"}, {obs(), 12'd0, rom_addr}, {want(1'b0, 10'd0, 1'b0), 22'd0});
      start = 1'b1;
      step();
      start = 1'b0;
      chk({name, "_start"}, {instr_valid, rom_addr}, 32'd0);
      foreach (exq[k]) begin
         step();
         chk($sformatf("%s_cyc%0d", name, k), obs(), want(exq[k].v, exq[k].pc, exq[k].done));
      end
`ifdef FETCH_ICOUNT_EN
      if (exp_halted) chk({name, "_icount"}, {16'd0, icnt}, exp_issued);
`endif
   endtask

   function automatic row_t mk(input logic s, input logic v, input int pc, input logic d);
      return '{start: s, v: v, pc: 10'(pc), done: d};
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      r4    = 1'b1;
      s4    = 1'b0;
      clear_prog();

      // Directed trace: taken branch at 5, squashed branch at 6, not-taken at 21,
      // halt at 23 with a simultaneous taken branch, start pulses in RUN and HALT.
      tbl[0]  = mk(1, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0);
      tbl[2]  = mk(0, 1, 1, 0);
      tbl[3]  = mk(1, 1, 2, 0);
      tbl[4]  = mk(0, 1, 3, 0);
      tbl[5]  = mk(0, 1, 4, 0);
      tbl[6]  = mk(1, 1, 5, 0);
      tbl[7]  = mk(0, 0, 0, 0);
      tbl[8]  = mk(0, 1, 20, 0);
      tbl[9]  = mk(0, 1, 21, 0);
      tbl[10] = mk(0, 1, 22, 0);
      tbl[11] = mk(0, 1, 23, 0);
      tbl[12] = mk(0, 0, 0, 1);
      tbl[13] = mk(0, 0, 0, 1);
      tbl[14] = mk(1, 0, 0, 0);
      tbl[15] = mk(0, 1, 0, 0);
      tbl[16] = mk(0, 1, 1, 0);

      step();
      reset = 1'b0;
      r4    = 1'b0;
      chk("reset_state", {obs(), 12'd0, rom_addr}, 32'd0);

      // 4-bit PC: no halt in the program, so PcOut wraps 15 -> 0 without a bubble.
      s4 = 1'b1;
      step();
      s4 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("wrap4_cyc%0d", k), {v4, pc4}, {1'b1, 4'(k % 16)});
      end

      br[5] = 1'b1;  tk[5] = 1'b1;  tg[5] = 10'd20;
      br[6] = 1'b1;  tk[6] = 1'b1;  tg[6] = 10'd40;
      br[21] = 1'b1; tk[21] = 1'b0; tg[21] = 10'd50;
      br[23] = 1'b1; tk[23] = 1'b1; tg[23] = 10'd30;
      rom[23] = 9'h1FF;
      for (int i = 0; i < 17; i++) begin
         start = tbl[i].start;
         step();
         chk($sformatf("trace_row%0d", i), obs(), want(tbl[i].v, tbl[i].pc, tbl[i].done));
      end
      start = 1'b0;

      // Small halting program.
      clear_prog();
      rom[0] = 9'h000; rom[1] = 9'h040; rom[2] = 9'h0C0; rom[3] = 9'h1FF;
      run_prog("prog4", 50);

      // Reset in the cycle the taken branch resolves.
      clear_prog();
      br[5] = 1'b1; tk[5] = 1'b1; tg[5] = 10'd20;
      reset = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      begin
         int   n = 0;
         logic hit = 1'b0;
         while (n < 20 && !hit) begin
            step();
            hit = instr_valid && pc_out == 10'd5;
            n++;
         end
         chk("reach_branch", {31'd0, hit}, 32'd1);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_mid_branch", {obs(), 12'd0, rom_addr}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("idle_after_reset%0d", k), {30'd0, instr_valid, done}, 32'd0);
      end

      // Random programs in the low 64 words with one halt word.
      for (int r = 0; r < 4; r++) begin
         int h;
         clear_prog();
         for (int a = 0; a < 64; a++) begin
            rom[a] = 9'($urandom_range(0, 9'h1FE));
            br[a]  = ($urandom_range(0, 3) == 0);
            tk[a]  = 1'($urandom_range(0, 1));
            tg[a]  = 10'($urandom_range(0, 63));
         end
         h = $urandom_range(10, 63);
         rom[h] = 9'h1FF;
         run_prog($sformatf("rand%0d", r), 200);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
